muldiv_unit: RTL and testbench
==============================

Name: muldiv_unit

Overview:
- Iterative RV32M multiply/divide execution unit.
- Consumes the two register-file read operands (rs1/rs2 values) and the destination index from decode.
- Produces a single write-back tuple (rd, result) for the register-file write port, using a valid/ready handshake on both sides.
- Sits between the operand-read stage and the write-back mux; the pipeline stalls on ready_in while the unit is busy.

Parameters:
- XLEN, 32, operand/result width; only 32 is supported.
- CNT_W, 6, iteration counter width; must satisfy 2^CNT_W > XLEN.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- resetn  input  1  synchronous, active-low reset.
- flush  input  1  abort any in-flight or pending operation.
- valid_in  input  1  operation request.
- ready_in  output  1  unit can accept a request this cycle.
- funct3  input  3  0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 DIV, 5 DIVU, 6 REM, 7 REMU.
- rs1_val  input  XLEN  operand a (dividend / multiplicand).
- rs2_val  input  XLEN  operand b (divisor / multiplier).
- rd_in  input  5  destination register index.
- valid_out  output  1  result valid.
- ready_out  input  1  write-back consumer accepts the result.
- result  output  XLEN  result value.
- rd_out  output  5  destination index for the write port.

Behaviour:
- Clock and reset: one clock, clk. Reset is resetn, synchronous, active-low; it is sampled only on the rising edge of clk.
- Reset values:
  - state = IDLE.
  - valid_out = 0, result = 0, rd_out = 0.
  - All internal accumulators and the counter = 0.
  - ready_in = 1 on the first cycle after reset.
- States: IDLE, CALC, FIX, DONE.
- ready_in is combinational and equals (state==IDLE). Acceptance happens at the edge where valid_in & ready_in & !flush.
- On accept:
  - Latch funct3 and rd_in.
  - Signed ops (MULH, DIV, REM, and rs1 of MULHSU): store operand magnitudes and record the result sign.
    - MULH: result sign = sign(a) ^ sign(b).
    - MULHSU: result sign = sign(a).
    - DIV: result sign = sign(a) ^ sign(b).
    - REM: result sign = sign(a).
  - Counter = 0.
  - Next state is CALC, except for the special cases below.
- Special cases, all going to DONE directly, with valid_out high at the edge after accept (1-cycle latency):
  - DIV/DIVU with b==0: result = 0xFFFFFFFF.
  - REM/REMU with b==0: result = a.
  - DIV with a==0x80000000 and b==0xFFFFFFFF: result = 0x80000000.
  - REM with the same operands: result = 0.
- CALC:
  - One radix-2 step per cycle: shift-add for multiply (64-bit product), restoring subtract for divide.
  - Counter increments each cycle; after XLEN steps (counter==XLEN-1 at the edge) go to FIX.
- FIX:
  - Apply two's-complement negation if the recorded sign is set.
  - Select the output: product low word (MUL), product high word (MULH/MULHSU/MULHU), quotient (DIV/DIVU), or remainder (REM/REMU).
  - Register result and rd_out; go to DONE.
- Normal latency: valid_out rises exactly XLEN+2 = 34 edges after the accept edge.
- DONE:
  - valid_out = 1; result and rd_out are held stable until ready_out.
  - On valid_out & ready_out, the next state is IDLE and valid_out = 0.
  - No back-to-back accept: minimum spacing between accepts is one IDLE cycle.
- flush: at any edge with flush=1, the next state is IDLE and valid_out = 0. No request is accepted on that edge, even if valid_in=1. A result in DONE is discarded.
- Reset mid-operation: resetn=0 at any edge overrides flush and handshakes; all reset values apply.
- rd_in==0 is processed normally. rd_out=0 is emitted and the register file discards the write.
- valid_out is never asserted outside DONE; ready_out is ignored outside DONE.

Test Plan:
- MUL a=7, b=-3 (0xFFFFFFFD) -> valid_out 34 cycles after accept, result=0xFFFFFFEB, rd_out=rd_in.
- MULH a=0x80000000, b=0x80000000 -> 0x40000000. MULHU a=b=0xFFFFFFFF -> 0xFFFFFFFE. MULHSU a=-1, b=0xFFFFFFFF -> 0xFFFFFFFF.
- DIV a=-7, b=2 -> 0xFFFFFFFD (-3). REM a=-7, b=2 -> 0xFFFFFFFF (-1). DIVU a=100, b=7 -> 14. REMU a=100, b=7 -> 2. Each takes 34-cycle latency.
- DIVU a=5, b=0 -> 0xFFFFFFFF after 1 cycle. REM a=5, b=0 -> 5. DIV 0x80000000 / 0xFFFFFFFF -> 0x80000000. REM with the same operands -> 0.
- Hold ready_out=0 for 10 cycles in DONE -> result and rd_out stable, ready_in=0. Then ready_out=1 -> IDLE next cycle and ready_in=1.
- flush at CALC cycle 10 with valid_in=1 -> no valid_out, IDLE next cycle, nothing accepted. A new DIVU then completes correctly. resetn=0 mid-CALC -> valid_out=0, result=0 next cycle.

Source files
------------

// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit: radix-2 shift-add multiply and
// restoring divide, one step per cycle, valid/ready on both sides.
module muldiv_unit #(
    parameter int XLEN  = 32,
    parameter int CNT_W = 6
) (
    input  logic            clk,
    input  logic            resetn,
    input  logic            flush,
    input  logic            valid_in,
    output logic            ready_in,
    input  logic [2:0]      funct3,
    input  logic [XLEN-1:0] rs1_val,
    input  logic [XLEN-1:0] rs2_val,
    input  logic [4:0]      rd_in,
    output logic            valid_out,
    input  logic            ready_out,
    output logic [XLEN-1:0] result,
    output logic [4:0]      rd_out
);

    typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic [2:0]          r_op;
    logic [4:0]          r_rd;
    logic                r_sign;
    logic                r_valid;
    logic [XLEN-1:0]     r_b;
    logic [2*XLEN-1:0]   r_acc;
    logic [CNT_W-1:0]    r_cnt;
    logic [XLEN-1:0]     r_result;

    logic                w_accept;
    logic                w_last;
    logic                w_a_neg;
    logic                w_b_neg;
    logic                w_a_sgn;
    logic                w_b_sgn;
    logic                w_sign;
    logic                w_b_zero;
    logic                w_ovf;
    logic                w_special;
    logic [XLEN-1:0]     w_a_mag;
    logic [XLEN-1:0]     w_b_mag;
    logic [XLEN-1:0]     w_spec_res;
    logic [XLEN:0]       w_add;
    logic [2*XLEN-1:0]   w_mul_nxt;
    logic [2*XLEN:0]     w_shl;
    logic [XLEN:0]       w_diff;
    logic [2*XLEN-1:0]   w_div_nxt;
    logic [2*XLEN-1:0]   w_prod;
    logic [XLEN-1:0]     w_div_sel;
    logic [XLEN-1:0]     w_div_res;
    logic [XLEN-1:0]     w_fix_res;

    assign ready_in  = (r_state == IDLE);
    assign valid_out = r_valid;
    assign result    = r_result;
    assign rd_out    = r_rd;

    assign w_accept = valid_in & ready_in & ~flush;
    assign w_last   = (r_cnt == CNT_W'(XLEN - 1));

    // MULH/MULHSU/DIV/REM treat rs1 as signed; MULH/DIV/REM also rs2
    assign w_a_neg = rs1_val[XLEN-1];
    assign w_b_neg = rs2_val[XLEN-1];
    assign w_a_sgn = (funct3 == 3'd1) | (funct3 == 3'd2) |
                     (funct3 == 3'd4) | (funct3 == 3'd6);
    assign w_b_sgn = (funct3 == 3'd1) | (funct3 == 3'd4) |
                     (funct3 == 3'd6);
    assign w_a_mag = (w_a_sgn & w_a_neg) ? -rs1_val : rs1_val;
    assign w_b_mag = (w_b_sgn & w_b_neg) ? -rs2_val : rs2_val;

    always_comb begin
        w_sign = 1'b0;
        unique case (funct3)
            3'd1:    w_sign = w_a_neg ^ w_b_neg;
            3'd2:    w_sign = w_a_neg;
            3'd4:    w_sign = w_a_neg ^ w_b_neg;
            3'd6:    w_sign = w_a_neg;
            default: w_sign = 1'b0;
        endcase
    end

    assign w_b_zero  = (rs2_val == '0);
    assign w_ovf     = funct3[2] & ~funct3[0] &
                       (rs1_val == {1'b1, {(XLEN-1){1'b0}}}) &
                       (rs2_val == '1);
    assign w_special = funct3[2] & (w_b_zero | w_ovf);
    assign w_spec_res = funct3[1] ? (w_b_zero ? rs1_val : '0)
                                  : (w_b_zero ? '1
                                              : {1'b1, {(XLEN-1){1'b0}}});

    // r_acc = {hi, lo}; multiplier bits consumed from lo as product shifts in
    assign w_add     = {1'b0, r_acc[2*XLEN-1:XLEN]} +
                       (r_acc[0] ? {1'b0, r_b} : '0);
    assign w_mul_nxt = {w_add, r_acc[XLEN-1:1]};

    // r_acc = {remainder, quotient/dividend}
    assign w_shl     = {r_acc, 1'b0};
    assign w_diff    = w_shl[2*XLEN:XLEN] - {1'b0, r_b};
    assign w_div_nxt = w_diff[XLEN] ? w_shl[2*XLEN-1:0]
                                    : {w_diff[XLEN-1:0],
                                       w_shl[XLEN-1:1], 1'b1};

    assign w_prod    = r_sign ? -r_acc : r_acc;
    assign w_div_sel = r_op[1] ? r_acc[2*XLEN-1:XLEN] : r_acc[XLEN-1:0];
    assign w_div_res = r_sign ? -w_div_sel : w_div_sel;
    assign w_fix_res = r_op[2] ? w_div_res :
                       (r_op[1:0] == 2'd0) ? w_prod[XLEN-1:0]
                                           : w_prod[2*XLEN-1:XLEN];

    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            IDLE: if (w_accept) w_state_nxt = w_special ? DONE : CALC;
            CALC: if (w_last) w_state_nxt = FIX;
            FIX:  w_state_nxt = DONE;
            DONE: if (r_valid & ready_out) w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
        if (flush) w_state_nxt = IDLE;
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_state  <= IDLE;
            r_op     <= '0;
            r_rd     <= '0;
            r_sign   <= 1'b0;
            r_valid  <= 1'b0;
            r_b      <= '0;
            r_acc    <= '0;
            r_cnt    <= '0;
            r_result <= '0;
        end else begin
            r_state <= w_state_nxt;
            // valid follows DONE one cycle late and drops on handshake/flush
            r_valid <= (r_state == DONE) & (w_state_nxt == DONE);
            unique case (r_state)
                IDLE: if (w_accept) begin
                    r_op   <= funct3;
                    r_rd   <= rd_in;
                    r_sign <= w_sign;
                    r_cnt  <= '0;
                    if (w_special) begin
                        r_result <= w_spec_res;
                    end else if (funct3[2]) begin
                        r_b   <= w_b_mag;
                        r_acc <= {{XLEN{1'b0}}, w_a_mag};
                    end else begin
                        r_b   <= w_a_mag;
                        r_acc <= {{XLEN{1'b0}}, w_b_mag};
                    end
                end
                CALC: begin
                    r_acc <= r_op[2] ? w_div_nxt : w_mul_nxt;
                    r_cnt <= r_cnt + CNT_W'(1);
                end
                FIX:     r_result <= w_fix_res;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed-vector bench for muldiv_unit: results, latency, hold,
// flush and mid-operation reset.
module tb_muldiv_unit;

    logic        clk = 1'b0;
    logic        resetn;
    logic        flush;
    logic        valid_in;
    logic        ready_in;
    logic [2:0]  funct3;
    logic [31:0] rs1_val;
    logic [31:0] rs2_val;
    logic [4:0]  rd_in;
    logic        valid_out;
    logic        ready_out;
    logic [31:0] result;
    logic [4:0]  rd_out;

    int n_tests = 0;
    int n_fail  = 0;

    muldiv_unit dut (
        .clk       (clk),
        .resetn    (resetn),
        .flush     (flush),
        .valid_in  (valid_in),
        .ready_in  (ready_in),
        .funct3    (funct3),
        .rs1_val   (rs1_val),
        .rs2_val   (rs2_val),
        .rd_in     (rd_in),
        .valid_out (valid_out),
        .ready_out (ready_out),
        .result    (result),
        .rd_out    (rd_out)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic accept(input logic [2:0] f, input logic [31:0] a,
                          input logic [31:0] b, input logic [4:0] rd);
        funct3   = f;
        rs1_val  = a;
        rs2_val  = b;
        rd_in    = rd;
        valid_in = 1'b1;
        tick();
        valid_in = 1'b0;
    endtask

    task automatic run_op(input string tag, input logic [2:0] f,
                          input logic [31:0] a, input logic [31:0] b,
                          input logic [4:0] rd, input logic [31:0] exp,
                          input int exp_lat);
        int lat;
        check({tag, "_rdyin"}, 32'(ready_in), 32'd1);
        accept(f, a, b, rd);
        lat = 0;
        while (!valid_out && lat < 100) begin
            tick();
            lat++;
        end
        check({tag, "_lat"}, 32'(lat), 32'(exp_lat));
        check({tag, "_res"}, result, exp);
        check({tag, "_rd"}, 32'(rd_out), 32'(rd));
    endtask

    task automatic release_res(input string tag);
        ready_out = 1'b1;
        tick();
        ready_out = 1'b0;
        check({tag, "_vdrop"}, 32'(valid_out), 32'd0);
        check({tag, "_idle"}, 32'(ready_in), 32'd1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        resetn    = 1'b0;
        flush     = 1'b0;
        valid_in  = 1'b0;
        ready_out = 1'b0;
        funct3    = '0;
        rs1_val   = '0;
        rs2_val   = '0;
        rd_in     = '0;
        repeat (3) tick();
        resetn = 1'b1;
        check("rst_valid", 32'(valid_out), 32'd0);
        check("rst_result", result, 32'd0);
        check("rst_rd", 32'(rd_out), 32'd0);
        check("rst_ready", 32'(ready_in), 32'd1);

        run_op("mul", 3'd0, 32'd7, 32'hFFFF_FFFD, 5'd3, 32'hFFFF_FFEB, 34);
        release_res("mul");
        run_op("mulh", 3'd1, 32'h8000_0000, 32'h8000_0000, 5'd4,
               32'h4000_0000, 34);
        release_res("mulh");
        run_op("mulhsu", 3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd6,
               32'hFFFF_FFFF, 34);
        release_res("mulhsu");
        run_op("div", 3'd4, 32'hFFFF_FFF9, 32'd2, 5'd7, 32'hFFFF_FFFD, 34);
        release_res("div");
        run_op("rem", 3'd6, 32'hFFFF_FFF9, 32'd2, 5'd8, 32'hFFFF_FFFF, 34);
        release_res("rem");
        run_op("divu", 3'd5, 32'd100, 32'd7, 5'd9, 32'd14, 34);
        release_res("divu");
        run_op("remu", 3'd7, 32'd100, 32'd7, 5'd0, 32'd2, 34);
        release_res("remu");
        run_op("divu0", 3'd5, 32'd5, 32'd0, 5'd10, 32'hFFFF_FFFF, 1);
        release_res("divu0");
        run_op("rem0", 3'd6, 32'd5, 32'd0, 5'd11, 32'd5, 1);
        release_res("rem0");
        run_op("divovf", 3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 5'd12,
               32'h8000_0000, 1);
        release_res("divovf");
        run_op("removf", 3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 5'd13,
               32'd0, 1);
        release_res("removf");

        run_op("mulhu", 3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd21,
               32'hFFFF_FFFE, 34);
        for (int i = 0; i < 10; i++) begin
            tick();
            check("hold_res", result, 32'hFFFF_FFFE);
            check("hold_rd", 32'(rd_out), 32'd21);
            check("hold_valid", 32'(valid_out), 32'd1);
            check("hold_rdyin", 32'(ready_in), 32'd0);
        end
        release_res("hold");

        accept(3'd5, 32'd1000, 32'd3, 5'd15);
        repeat (10) tick();
        check("fl_busy", 32'(ready_in), 32'd0);
        flush    = 1'b1;
        valid_in = 1'b1;
        funct3   = 3'd0;
        rs1_val  = 32'd2;
        rs2_val  = 32'd2;
        tick();
        flush    = 1'b0;
        valid_in = 1'b0;
        check("fl_valid", 32'(valid_out), 32'd0);
        check("fl_idle", 32'(ready_in), 32'd1);
        tick();
        check("fl_noacc", 32'(ready_in), 32'd1);
        repeat (40) begin
            tick();
            if (valid_out) check("fl_spurious", 32'(valid_out), 32'd0);
        end
        check("fl_quiet", 32'(valid_out), 32'd0);
        run_op("fl_divu", 3'd5, 32'd100, 32'd7, 5'd16, 32'd14, 34);
        release_res("fl_divu");

        accept(3'd0, 32'd7, 32'd3, 5'd17);
        repeat (5) tick();
        resetn = 1'b0;
        tick();
        check("mr_valid", 32'(valid_out), 32'd0);
        check("mr_result", result, 32'd0);
        check("mr_rd", 32'(rd_out), 32'd0);
        check("mr_ready", 32'(ready_in), 32'd1);
        resetn = 1'b1;
        tick();
        run_op("mr_mul", 3'd0, 32'd7, 32'd3, 5'd18, 32'd21, 34);
        release_res("mr_mul");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
